// File: rtl/sdr_toggle_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sdr_toggle_arbiter_if
// Brief    : Client-side and controller-side bundle of the SDRAM toggle arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface sdr_toggle_arbiter_if #(
   parameter int N_CH = 4,
   parameter int AW   = 27,
   parameter int DW   = 64
);
   localparam int c_CW = $clog2(N_CH);

   logic [N_CH*AW-1:0]     ch_addr;
   logic [N_CH*DW-1:0]     ch_data;
   logic [N_CH*DW/8-1:0]   ch_be;
   logic [N_CH-1:0]        ch_rw;
   logic [N_CH-1:0]        ch_req;
   logic [N_CH-1:0]        ch_ack;
   logic [N_CH*DW-1:0]     ch_q;

   logic [AW-1:0]          sdr_addr;
   logic [DW-1:0]          sdr_data;
   logic [DW/8-1:0]        sdr_be;
   logic                   sdr_rw;
   logic                   sdr_req;
   logic                   sdr_ack;
   logic [DW-1:0]          sdr_q;

   logic                   busy;
   logic [c_CW-1:0]        grant_ch;

   // master: clients plus controller; slave: the arbiter itself
   modport master (
      output ch_addr, ch_data, ch_be, ch_rw, ch_req, sdr_ack, sdr_q,
      input  ch_ack, ch_q, sdr_addr, sdr_data, sdr_be, sdr_rw, sdr_req, busy, grant_ch
   );

   modport slave (
      input  ch_addr, ch_data, ch_be, ch_rw, ch_req, sdr_ack, sdr_q,
      output ch_ack, ch_q, sdr_addr, sdr_data, sdr_be, sdr_rw, sdr_req, busy, grant_ch
   );
endinterface
`default_nettype wire

// File: rtl/sdr_toggle_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdr_toggle_arbiter
// Brief    : N-channel toggle-handshake arbiter onto a single SDRAM toggle port.
//            Optional anti-starvation override enabled by SDR_ARB_STARVE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sdr_toggle_arbiter #(
   parameter int N_CH         = 4,
   parameter int AW           = 27,
   parameter int DW           = 64,
   parameter int PRIO_RR      = 0,
   parameter int STARVE_LIMIT = 255
) (
   input  logic                clk,
   input  logic                reset,
   sdr_toggle_arbiter_if.slave bus
);
   localparam int c_CW = $clog2(N_CH);
   localparam int c_BW = DW / 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t              r_state;
   logic [N_CH-1:0]     r_ch_ack;
   logic [N_CH*DW-1:0]  r_ch_q;
   logic [AW-1:0]       r_sdr_addr;
   logic [DW-1:0]       r_sdr_data;
   logic [c_BW-1:0]     r_sdr_be;
   logic                r_sdr_rw;
   logic                r_sdr_req;
   logic                r_busy;
   logic                r_req_snap;
   logic [c_CW-1:0]     r_grant;
   logic [c_CW-1:0]     r_last;

   logic [N_CH-1:0]     w_pending;
   logic                w_grant;
   logic                w_done;
   logic [c_CW-1:0]     w_base_win;
   logic [c_CW-1:0]     w_win;

   function automatic logic [c_CW-1:0] f_pick_fixed(input logic [N_CH-1:0] p);
      logic [c_CW-1:0] v_win;
      v_win = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (p[i]) v_win = c_CW'(i);
      end
      return v_win;
   endfunction

   // First pending index strictly after the last grant, wrapping to 0
   function automatic logic [c_CW-1:0] f_pick_rr(input logic [N_CH-1:0] p,
                                                 input logic [c_CW-1:0] last);
      logic [c_CW-1:0] v_win;
      logic            v_found;
      int              v_idx;
      v_win   = '0;
      v_found = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         v_idx = int'(last) + k;
         if (v_idx >= N_CH) v_idx = v_idx - N_CH;
         if (!v_found && p[v_idx]) begin
            v_win   = c_CW'(v_idx);
            v_found = 1'b1;
         end
      end
      return v_win;
   endfunction

   assign w_pending  = bus.ch_req ^ r_ch_ack;
   assign w_grant    = (r_state == ST_IDLE) && (|w_pending);
   assign w_done     = (r_state == ST_BUSY) && (r_sdr_req == bus.sdr_ack);
   assign w_base_win = (PRIO_RR != 0) ? f_pick_rr(w_pending, r_last) : f_pick_fixed(w_pending);

`ifdef SDR_ARB_STARVE_EN
   logic [7:0]      r_wait [N_CH];
   logic [N_CH-1:0] w_starved;

   always_comb begin
      w_starved = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_starved[i] = w_pending[i] && (32'(r_wait[i]) >= STARVE_LIMIT);
      end
   end

   // The in-flight channel is already served, so it does not accumulate wait time
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) r_wait[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (w_grant && (w_win == c_CW'(i))) begin
               r_wait[i] <= '0;
            end else if (w_pending[i] && !(r_busy && (r_grant == c_CW'(i))) &&
                         (r_wait[i] != 8'hFF)) begin
               r_wait[i] <= r_wait[i] + 8'd1;
            end
         end
      end
   end

   assign w_win = (|w_starved) ? f_pick_fixed(w_starved) : w_base_win;
`else
   assign w_win = w_base_win;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_ch_ack   <= '0;
         r_ch_q     <= '0;
         r_sdr_addr <= '0;
         r_sdr_data <= '0;
         r_sdr_be   <= '0;
         r_sdr_rw   <= 1'b0;
         r_sdr_req  <= 1'b0;
         r_busy     <= 1'b0;
         r_req_snap <= 1'b0;
         r_grant    <= '0;
         r_last     <= c_CW'(N_CH - 1);
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant) begin
                  r_sdr_addr <= bus.ch_addr[int'(w_win)*AW +: AW];
                  r_sdr_data <= bus.ch_data[int'(w_win)*DW +: DW];
                  r_sdr_be   <= bus.ch_be[int'(w_win)*c_BW +: c_BW];
                  r_sdr_rw   <= bus.ch_rw[w_win];
                  r_sdr_req  <= ~r_sdr_req;
                  // Acking with the snapshot keeps a mid-flight re-toggle pending
                  r_req_snap <= bus.ch_req[w_win];
                  r_grant    <= w_win;
                  r_last     <= w_win;
                  r_busy     <= 1'b1;
                  r_state    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (w_done) begin
                  r_ch_ack[r_grant] <= r_req_snap;
                  if (r_sdr_rw) r_ch_q[int'(r_grant)*DW +: DW] <= bus.sdr_q;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.ch_ack   = r_ch_ack;
   assign bus.ch_q     = r_ch_q;
   assign bus.sdr_addr = r_sdr_addr;
   assign bus.sdr_data = r_sdr_data;
   assign bus.sdr_be   = r_sdr_be;
   assign bus.sdr_rw   = r_sdr_rw;
   assign bus.sdr_req  = r_sdr_req;
   assign bus.busy     = r_busy;
   assign bus.grant_ch = r_grant;
endmodule
`default_nettype wire

// File: tb/tb_sdr_toggle_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdr_toggle_arbiter
// Brief    : Directed scoreboard bench; fixed-priority and round-robin instances
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdr_toggle_arbiter;
   localparam int N_CH = 4;
   localparam int AW   = 27;
   localparam int DW   = 64;
   localparam int BW   = DW / 8;
   localparam int LAT  = 2;
   localparam logic [63:0] c_Q_BASE = 64'hDEAD_BEEF_0000_1235;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            ch;
      logic [AW-1:0] addr;
      logic          rw;
      logic [DW-1:0] data;
      logic [BW-1:0] be;
   } exp_t;

   exp_t exp_a[$];
   exp_t exp_b[$];
   int   hist_a[$];

   sdr_toggle_arbiter_if #(.N_CH(N_CH), .AW(AW), .DW(DW)) if_a ();
   sdr_toggle_arbiter_if #(.N_CH(N_CH), .AW(AW), .DW(DW)) if_b ();

   sdr_toggle_arbiter #(.N_CH(N_CH), .AW(AW), .DW(DW), .PRIO_RR(0), .STARVE_LIMIT(16)) dut_a (
      .clk(clk), .reset(reset), .bus(if_a)
   );
   sdr_toggle_arbiter #(.N_CH(N_CH), .AW(AW), .DW(DW), .PRIO_RR(1), .STARVE_LIMIT(16)) dut_b (
      .clk(clk), .reset(reset), .bus(if_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Controller models: ack LAT negedges after a new request, data derived from address
   initial begin : ctl_a
      int cnt;
      cnt = 0;
      if_a.sdr_ack = 1'b0;
      if_a.sdr_q   = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            if_a.sdr_ack = 1'b0;
            cnt = 0;
         end else if (if_a.sdr_req != if_a.sdr_ack) begin
            cnt++;
            if (cnt >= LAT) begin
               if_a.sdr_q   = c_Q_BASE ^ 64'(if_a.sdr_addr);
               if_a.sdr_ack = if_a.sdr_req;
               cnt = 0;
            end
         end
      end
   end

   initial begin : ctl_b
      int cnt;
      cnt = 0;
      if_b.sdr_ack = 1'b0;
      if_b.sdr_q   = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            if_b.sdr_ack = 1'b0;
            cnt = 0;
         end else if (if_b.sdr_req != if_b.sdr_ack) begin
            cnt++;
            if (cnt >= LAT) begin
               if_b.sdr_q   = c_Q_BASE ^ 64'(if_b.sdr_addr);
               if_b.sdr_ack = if_b.sdr_req;
               cnt = 0;
            end
         end
      end
   end

   // Grant monitors: a rising busy marks a new grant; compare against the scoreboard
   initial begin : mon_a
      logic prev_busy;
      exp_t e;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (if_a.busy && !prev_busy) begin
            hist_a.push_back(int'(if_a.grant_ch));
            if (exp_a.size() > 0) begin
               e = exp_a.pop_front();
               chk("a_grant_ch", 64'(if_a.grant_ch), 64'(e.ch));
               chk("a_sdr_addr", 64'(if_a.sdr_addr), 64'(e.addr));
               chk("a_sdr_rw",   64'(if_a.sdr_rw),   64'(e.rw));
               if (!e.rw) begin
                  chk("a_sdr_data", if_a.sdr_data, e.data);
                  chk("a_sdr_be",   64'(if_a.sdr_be), 64'(e.be));
               end
            end
         end
         prev_busy = if_a.busy;
      end
   end

   initial begin : mon_b
      logic prev_busy;
      exp_t e;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (if_b.busy && !prev_busy && exp_b.size() > 0) begin
            e = exp_b.pop_front();
            chk("b_grant_ch", 64'(if_b.grant_ch), 64'(e.ch));
            chk("b_sdr_addr", 64'(if_b.sdr_addr), 64'(e.addr));
         end
         prev_busy = if_b.busy;
      end
   end

   task automatic drive_a(input int ch, input logic rw, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [BW-1:0] be, input bit push);
      exp_t e;
      if_a.ch_addr[ch*AW +: AW] = addr;
      if_a.ch_data[ch*DW +: DW] = data;
      if_a.ch_be[ch*BW +: BW]   = be;
      if_a.ch_rw[ch]            = rw;
      if_a.ch_req[ch]           = ~if_a.ch_req[ch];
      if (push) begin
         e.ch = ch; e.addr = addr; e.rw = rw; e.data = data; e.be = be;
         exp_a.push_back(e);
      end
   endtask

   task automatic wait_ack_a(input int ch, input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (if_a.ch_ack[ch] === if_a.ch_req[ch]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk(tag, 64'(ok), 64'd1);
   endtask

   initial begin : main
      exp_t e;
      int   n0, n3, n0_before, first3;
      int   remaining [N_CH];
      bit   ok;

      if_a.ch_addr = '0; if_a.ch_data = '0; if_a.ch_be = '0; if_a.ch_rw = '1; if_a.ch_req = '0;
      if_b.ch_addr = '0; if_b.ch_data = '0; if_b.ch_be = '0; if_b.ch_rw = '1; if_b.ch_req = '0;
      for (int c = 0; c < N_CH; c++) if_b.ch_addr[c*AW +: AW] = AW'(c * 'h100 + 'h40);

      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ch_ack",   64'(if_a.ch_ack),   64'd0);
      chk("rst_ch_q",     64'(|if_a.ch_q),    64'd0);
      chk("rst_sdr_addr", 64'(if_a.sdr_addr), 64'd0);
      chk("rst_sdr_data", if_a.sdr_data,      64'd0);
      chk("rst_sdr_be",   64'(if_a.sdr_be),   64'd0);
      chk("rst_sdr_rw",   64'(if_a.sdr_rw),   64'd0);
      chk("rst_sdr_req",  64'(if_a.sdr_req),  64'd0);
      chk("rst_busy",     64'(if_a.busy),     64'd0);
      chk("rst_grant_ch", 64'(if_a.grant_ch), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Single read on channel 2
      drive_a(2, 1'b1, 27'h0001234, '0, '0, 1'b1);
      @(negedge clk);
      chk("rd_busy", 64'(if_a.busy), 64'd1);
      wait_ack_a(2, "rd_ack_timeout");
      chk("rd_ch_ack",  64'(if_a.ch_ack), 64'h4);
      chk("rd_ch_q2",   if_a.ch_q[2*DW +: DW], 64'hDEAD_BEEF_0000_0001);
      chk("rd_ch_q0",   if_a.ch_q[0*DW +: DW], 64'd0);
      chk("rd_ch_q1",   if_a.ch_q[1*DW +: DW], 64'd0);
      chk("rd_ch_q3",   if_a.ch_q[3*DW +: DW], 64'd0);
      chk("rd_busy_done", 64'(if_a.busy), 64'd0);

      // Byte-enabled write on channel 1 leaves ch_q untouched
      drive_a(1, 1'b0, 27'h00ABCDE, 64'h1122_3344_5566_7788, 8'h0F, 1'b1);
      wait_ack_a(1, "wr_ack_timeout");
      chk("wr_ch_ack", 64'(if_a.ch_ack), 64'h6);
      chk("wr_ch_q1",  if_a.ch_q[1*DW +: DW], 64'd0);
      chk("wr_ch_q2",  if_a.ch_q[2*DW +: DW], 64'hDEAD_BEEF_0000_0001);

      // Fixed priority: all four toggle together, served 0,1,2,3
      for (int c = 0; c < N_CH; c++) drive_a(c, 1'b1, AW'((c + 1) * 'h100), '0, '0, 1'b1);
      for (int c = 0; c < N_CH; c++) wait_ack_a(c, "fix_ack_timeout");
      chk("fix_sb_empty", 64'(exp_a.size()), 64'd0);
      chk("fix_ch_q0", if_a.ch_q[0*DW +: DW], c_Q_BASE ^ 64'h100);
      chk("fix_ch_q3", if_a.ch_q[3*DW +: DW], c_Q_BASE ^ 64'h400);

      // Channel 0 re-toggles on every completion while channel 3 waits
      hist_a.delete();
      drive_a(0, 1'b1, 27'h10, '0, '0, 1'b0);
      drive_a(3, 1'b1, 27'h30, '0, '0, 1'b0);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (if_a.ch_ack[0] === if_a.ch_req[0]) drive_a(0, 1'b1, 27'h10, '0, '0, 1'b0);
      end
      n0 = 0; n3 = 0; n0_before = 0; first3 = -1;
      for (int i = 0; i < hist_a.size(); i++) begin
         if (hist_a[i] == 0) n0++;
         if (hist_a[i] == 3) begin
            n3++;
            if (first3 < 0) first3 = i;
         end
      end
      if (first3 >= 0) n0_before = first3;
`ifdef SDR_ARB_STARVE_EN
      chk("starve_ch3_grants", 64'(n3), 64'd1);
      ok = (n0_before >= 4) && (n0_before <= 7);
      chk("starve_ch0_before_ch3", 64'(ok), 64'd1);
`else
      chk("fixed_ch3_starved", 64'(n3), 64'd0);
      ok = (n0 >= 10);
      chk("fixed_ch0_hammer", 64'(ok), 64'd1);
`endif
      wait_ack_a(0, "hammer_ch0_timeout");
      wait_ack_a(3, "hammer_ch3_timeout");

      // Round-robin: four channels kept pending, expected order 0,1,2,3,0,1,2,3
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < N_CH; c++) begin
            e.ch = c; e.addr = AW'(c * 'h100 + 'h40); e.rw = 1'b1; e.data = '0; e.be = '0;
            exp_b.push_back(e);
         end
      end
      for (int c = 0; c < N_CH; c++) begin
         remaining[c] = 1;
         if_b.ch_req[c] = ~if_b.ch_req[c];
      end
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (exp_b.size() == 0) break;
         for (int c = 0; c < N_CH; c++) begin
            if ((if_b.ch_ack[c] === if_b.ch_req[c]) && remaining[c] > 0) begin
               if_b.ch_req[c] = ~if_b.ch_req[c];
               remaining[c]--;
            end
         end
      end
      chk("rr_sb_empty", 64'(exp_b.size()), 64'd0);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (if_b.ch_ack === if_b.ch_req) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("rr_drain_timeout", 64'(ok), 64'd1);

      // Reset while a read is in flight
      drive_a(0, 1'b1, 27'h77, '0, '0, 1'b0);
      @(negedge clk);
      chk("mid_busy", 64'(if_a.busy), 64'd1);
      #2;
      reset = 1'b1;
      if_a.ch_req = '0;
      if_b.ch_req = '0;
      #1;
      chk("mid_rst_busy",    64'(if_a.busy),    64'd0);
      chk("mid_rst_sdr_req", 64'(if_a.sdr_req), 64'd0);
      chk("mid_rst_ch_ack",  64'(if_a.ch_ack),  64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      drive_a(1, 1'b1, 27'h55, '0, '0, 1'b1);
      wait_ack_a(1, "post_rst_ack_timeout");
      chk("post_rst_ch_ack", 64'(if_a.ch_ack), 64'h2);
      chk("post_rst_ch_q1",  if_a.ch_q[1*DW +: DW], c_Q_BASE ^ 64'h55);
      chk("post_rst_ch_q2",  if_a.ch_q[2*DW +: DW], 64'd0);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
